sipo_deframer: RTL and testbench

Serial-in/parallel-out deframing receiver that consumes the single-bit stream produced by the team's parallel-in/serial-out shifter stage and rebuilds N-bit words. It detects a start bit, shifts in N data bits MSB first and checks a stop bit. It presents each word on a valid/ready output port with a one-word holding register and flags framing errors and overruns. It sits directly downstream of the PISO stage, on the same clock.

---
 rtl/sipo_deframer.sv | 99 +++++++++
 tb/tb_sipo_deframer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sipo_deframer.sv
// Deframing receiver: start bit, N data bits, stop bit -> N-bit word on a valid/ready port.
// Word visible the cycle after the stop-bit sample; one-word holding register, overrun drops the new word.
module sipo_deframer #(
    parameter int N         = 5,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         serial_in,
    input  logic         bit_en,
    output logic [N-1:0] parallel_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         frame_err,
    output logic         overrun,
    output logic         busy
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] bit_cnt, bit_cnt_nxt;
    logic [N-1:0]  shift_reg, shift_nxt;
    logic [N-1:0]  word_nxt;
    logic          valid_nxt;
    logic          ferr_nxt;
    logic          ovr_nxt;

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift_reg;
        word_nxt    = parallel_out;
        // A pending word is consumed whenever the handshake completes
        valid_nxt   = out_valid & ~out_ready;
        ferr_nxt    = 1'b0;
        ovr_nxt     = 1'b0;
        if (bit_en) begin
            case (state)
                IDLE: begin
                    if (!serial_in) begin
                        bit_cnt_nxt = '0;
                        state_nxt   = DATA;
                    end
                end
                DATA: begin
                    if (MSB_FIRST)
                        shift_nxt = {shift_reg[N-2:0], serial_in};
                    else
                        shift_nxt = {serial_in, shift_reg[N-1:1]};
                    if (bit_cnt == CW'(N-1))
                        state_nxt = STOP;
                    else
                        bit_cnt_nxt = bit_cnt + 1'b1;
                end
                STOP: begin
                    state_nxt = IDLE;
                    if (serial_in) begin
                        // Load when the register is empty or is being drained on this same edge
                        if (!out_valid || out_ready) begin
                            word_nxt  = shift_reg;
                            valid_nxt = 1'b1;
                        end else begin
                            ovr_nxt = 1'b1;
                        end
                    end else begin
                        ferr_nxt = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            parallel_out <= '0;
            out_valid    <= 1'b0;
            frame_err    <= 1'b0;
            overrun      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nxt;
            bit_cnt      <= bit_cnt_nxt;
            shift_reg    <= shift_nxt;
            parallel_out <= word_nxt;
            out_valid    <= valid_nxt;
            frame_err    <= ferr_nxt;
            overrun      <= ovr_nxt;
            busy         <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_sipo_deframer.sv
// Directed bench for sipo_deframer: MSB-first and LSB-first instances share one serial line.
module tb_sipo_deframer;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       serial_in = 1'b1;
    logic       bit_en = 1'b0;
    logic       out_ready = 1'b1;
    logic [4:0] po_m, po_l;
    logic       vld_m, vld_l, ferr_m, ferr_l, ovr_m, ovr_l, busy_m, busy_l;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sipo_deframer #(.N(5), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rstn(rstn), .serial_in(serial_in), .bit_en(bit_en),
        .parallel_out(po_m), .out_valid(vld_m), .out_ready(out_ready),
        .frame_err(ferr_m), .overrun(ovr_m), .busy(busy_m)
    );

    sipo_deframer #(.N(5), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rstn(rstn), .serial_in(serial_in), .bit_en(bit_en),
        .parallel_out(po_l), .out_valid(vld_l), .out_ready(out_ready),
        .frame_err(ferr_l), .overrun(ovr_l), .busy(busy_l)
    );

    typedef struct {
        logic [6:0] f;      // line bits, f[6] sent first
        bit         gap;    // insert a bit_en=0 cycle after each sampled bit
        logic [4:0] em;     // expected word, MSB-first instance
        logic [4:0] el;     // expected word, LSB-first instance
        bit         ev;     // expected out_valid after stop edge
        bit         eferr;  // expected frame_err after stop edge
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends a whole frame; returns just after the stop-bit edge.
    task automatic send_frame(input logic [6:0] f, input bit gap, input bit ready_on_stop);
        for (int i = 6; i >= 0; i--) begin
            serial_in = f[i];
            bit_en    = 1'b1;
            if (i == 0) begin
                chk("busy_before_stop", busy_m, 1);
                if (ready_on_stop) out_ready = 1'b1;
            end
            tick();
            if (gap && i != 0) begin
                bit_en    = 1'b0;
                serial_in = ~f[i];
                tick();
            end
        end
        serial_in = 1'b1;
    endtask

    initial begin
        tbl[0] = '{7'b0101011, 1'b0, 5'b10101, 5'b10101, 1'b1, 1'b0};
        tbl[1] = '{7'b0101011, 1'b1, 5'b10101, 5'b10101, 1'b1, 1'b0};
        tbl[2] = '{7'b0110001, 1'b1, 5'b11000, 5'b00011, 1'b1, 1'b0};
        tbl[3] = '{7'b0111110, 1'b0, 5'b11000, 5'b00011, 1'b0, 1'b1};
        tbl[4] = '{7'b0000011, 1'b0, 5'b00001, 5'b10000, 1'b1, 1'b0};

        #12;
        chk("rst_valid", vld_m, 0);
        chk("rst_po", po_m, 0);
        chk("rst_busy", busy_m, 0);
        @(negedge clk);
        rstn = 1'b1;
        tick();

        // Latency: stop bit sampled on the 7th edge, word visible right after it
        for (int i = 6; i >= 0; i--) begin
            serial_in = tbl[0].f[i];
            bit_en    = 1'b1;
            tick();
            if (i == 1) begin
                chk("lat_valid_early", vld_m, 0);
                chk("lat_busy", busy_m, 1);
            end
        end
        serial_in = 1'b1;
        chk("lat_valid", vld_m, 1);
        chk("lat_po", po_m, 5'b10101);
        chk("lat_busy_done", busy_m, 0);
        tick();
        chk("lat_drain", vld_m, 0);

        for (int v = 0; v < 5; v++) begin
            send_frame(tbl[v].f, tbl[v].gap, 1'b0);
            chk($sformatf("v%0d_valid_m", v), vld_m, tbl[v].ev);
            chk($sformatf("v%0d_valid_l", v), vld_l, tbl[v].ev);
            chk($sformatf("v%0d_po_m", v), po_m, tbl[v].em);
            chk($sformatf("v%0d_po_l", v), po_l, tbl[v].el);
            chk($sformatf("v%0d_ferr", v), ferr_m, tbl[v].eferr);
            chk($sformatf("v%0d_ovr", v), ovr_m, 0);
            bit_en = 1'b1;
            tick();
            chk($sformatf("v%0d_ferr_pulse", v), ferr_m, 0);
            chk($sformatf("v%0d_drain", v), vld_m, 0);
        end

        // Backpressure and overrun
        out_ready = 1'b0;
        send_frame(7'b0101011, 1'b0, 1'b0);
        chk("bp_valid1", vld_m, 1);
        chk("bp_po1", po_m, 5'b10101);
        send_frame(7'b0111001, 1'b0, 1'b0);
        chk("bp_ovr", ovr_m, 1);
        chk("bp_valid2", vld_m, 1);
        chk("bp_po_held", po_m, 5'b10101);
        tick();
        chk("bp_ovr_pulse", ovr_m, 0);
        out_ready = 1'b1;
        tick();
        chk("bp_drain", vld_m, 0);
        chk("bp_po_after", po_m, 5'b10101);

        // Accept and load on the same edge
        out_ready = 1'b0;
        send_frame(7'b0101011, 1'b0, 1'b0);
        send_frame(7'b0001111, 1'b0, 1'b1);
        chk("sim_valid", vld_m, 1);
        chk("sim_po", po_m, 5'b00111);
        chk("sim_ovr", ovr_m, 0);
        tick();
        chk("sim_drain", vld_m, 0);

        // Asynchronous reset mid-frame with a word pending
        out_ready = 1'b0;
        send_frame(7'b0101011, 1'b0, 1'b0);
        tick();
        for (int i = 6; i >= 3; i--) begin
            serial_in = tbl[0].f[i];
            bit_en    = 1'b1;
            tick();
        end
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_valid", vld_m, 0);
        chk("arst_po", po_m, 0);
        chk("arst_busy", busy_m, 0);
        chk("arst_ferr", ferr_m, 0);
        chk("arst_ovr", ovr_m, 0);
        serial_in = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        rstn = 1'b1;
        tick();
        chk("arst_idle", busy_m, 0);
        send_frame(7'b0110111, 1'b0, 1'b0);
        chk("arst_new_valid", vld_m, 1);
        chk("arst_new_po", po_m, 5'b11011);
        chk("arst_new_ferr", ferr_m, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
